// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//   Memory-stage data-access controller. Turns byte / halfword / word loads and
//   stores from the EX/MEM boundary into word-aligned, byte-enabled
//   transactions on a variable-latency req/ready RAM bus, and returns aligned,
//   sign/zero-extended load data. The pipeline is stalled until the access
//   completes.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | waiting for an access; misaligned accesses are rejected here
//   BUSY  | bus_req high, bus fields frozen, waiting for bus_ready/timeout
//   DONE  | one cycle with stall released so the pipeline advances
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   cpu_mem_w   store request (wins over cpu_mem_r when both are set)
//   cpu_mem_r   load request
//   cpu_addr    byte address
//   cpu_wdata   store data, right-justified
//   cpu_dmtype  000 word, 001 half, 010 half-u, 011 byte, 100 byte-u,
//               101..111 word
//   cpu_rdata   extended load data, valid in the DONE cycle, held afterwards
//   cpu_stall   pipeline freeze
//   cpu_err     one-cycle pulse on misalignment or timeout
//   bus_req     transaction request
//   bus_we      1 = write
//   bus_be      byte enables
//   bus_addr    word address
//   bus_wdata   lane-replicated store data
//   bus_rdata   read word, sampled with bus_ready
//   bus_ready   transaction completion
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_mem_w,
  input  logic          cpu_mem_r,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [2:0]    cpu_dmtype,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  output logic          cpu_err,
  output logic          bus_req,
  output logic          bus_we,
  output logic [3:0]    bus_be,
  output logic [AW-3:0] bus_addr,
  output logic [31:0]   bus_wdata,
  input  logic [31:0]   bus_rdata,
  input  logic          bus_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_t;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;

  // attributes of the access in flight, needed to pick the read lane
  size_t       lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_off;

  // request decode
  logic        access;
  size_t       req_size;
  logic        req_unsigned;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  // read lane extraction
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  assign access  = cpu_mem_w | cpu_mem_r;
  assign cnt_inc = cnt + 16'd1;

  always_comb begin
    req_size     = SZ_WORD;
    req_unsigned = 1'b0;
    case (cpu_dmtype)
      3'b001: req_size = SZ_HALF;
      3'b010: begin
        req_size     = SZ_HALF;
        req_unsigned = 1'b1;
      end
      3'b011: req_size = SZ_BYTE;
      3'b100: begin
        req_size     = SZ_BYTE;
        req_unsigned = 1'b1;
      end
      default: req_size = SZ_WORD;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SZ_HALF: misaligned = cpu_addr[0];
      SZ_BYTE: misaligned = 1'b0;
      default: misaligned = (cpu_addr[1:0] != 2'b00);
    endcase
  end

  // Sub-word store data is replicated across all lanes so the RAM only has
  // to honour the byte enables, whatever the offset.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = cpu_wdata;
    case (req_size)
      SZ_HALF: begin
        be_next    = 4'b0011 << cpu_addr[1:0];
        wdata_next = {2{cpu_wdata[15:0]}};
      end
      SZ_BYTE: begin
        be_next    = 4'b0001 << cpu_addr[1:0];
        wdata_next = {4{cpu_wdata[7:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = cpu_wdata;
      end
    endcase
  end

  always_comb begin
    lane_byte = bus_rdata[7:0];
    case (lat_off)
      2'd1:    lane_byte = bus_rdata[15:8];
      2'd2:    lane_byte = bus_rdata[23:16];
      2'd3:    lane_byte = bus_rdata[31:24];
      default: lane_byte = bus_rdata[7:0];
    endcase
    lane_half = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  end

  always_comb begin
    load_data = bus_rdata;
    case (lat_size)
      SZ_HALF: load_data = lat_unsigned ? {16'h0000, lane_half}
                                        : {{16{lane_half[15]}}, lane_half};
      SZ_BYTE: load_data = lat_unsigned ? {24'h000000, lane_byte}
                                        : {{24{lane_byte[7]}}, lane_byte};
      default: load_data = bus_rdata;
    endcase
  end

  // The request cycle must stall combinationally so EX/MEM holds the access
  // while it is being launched. Gated by rst so the freeze drops the moment
  // reset is applied, even if the pipeline still presents a request.
  assign cpu_stall = rst & ((state == S_BUSY) |
                            ((state == S_IDLE) & access & ~misaligned));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_be       <= '0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      cpu_rdata    <= '0;
      cpu_err      <= 1'b0;
      lat_size     <= SZ_WORD;
      lat_unsigned <= 1'b0;
      lat_off      <= 2'b00;
    end else begin
      cpu_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access) begin
            if (misaligned) begin
              cpu_err   <= 1'b1;
              cpu_rdata <= '0;
            end else begin
              bus_req      <= 1'b1;
              bus_we       <= cpu_mem_w;
              bus_be       <= be_next;
              bus_addr     <= cpu_addr[AW-1:2];
              bus_wdata    <= wdata_next;
              lat_size     <= req_size;
              lat_unsigned <= req_unsigned;
              lat_off      <= cpu_addr[1:0];
              cnt          <= '0;
              state        <= S_BUSY;
            end
          end
        end

        S_BUSY: begin
          cnt <= cnt_inc;
          // ready on the final allowed cycle still counts as success
          if (bus_ready) begin
            bus_req <= 1'b0;
            if (!bus_we) begin
              cpu_rdata <= load_data;
            end
            state <= S_DONE;
          end else if (cnt_inc == TO_LIMIT) begin
            bus_req   <= 1'b0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b1;
            state     <= S_DONE;
          end
        end

        // The request is still on the inputs here; it is deliberately not
        // relaunched because the pipeline retires it on this edge.
        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic        cpu_mem_w, cpu_mem_r;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_dmtype;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, cpu_err;
  logic        bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ready;

  // second instance with a short timeout and a RAM that never answers
  logic        to_mem_r;
  logic [31:0] to_addr;
  logic [31:0] to_rdata;
  logic        to_stall, to_err, to_req, to_we;
  logic [3:0]  to_be;
  logic [29:0] to_baddr;
  logic [31:0] to_bwdata;
  logic [31:0] to_bus_rdata = 32'hA5A5A5A5;
  logic        to_ready = 1'b0;

  int tests  = 0;
  int failed = 0;

  logic [31:0] ram [0:1023];
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT(255), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_mem_w(cpu_mem_w), .cpu_mem_r(cpu_mem_r), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_dmtype(cpu_dmtype),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  dmem_ctrl #(.TIMEOUT(4), .AW(32)) dut_to (
    .clk(clk), .rst(rst),
    .cpu_mem_w(1'b0), .cpu_mem_r(to_mem_r), .cpu_addr(to_addr),
    .cpu_wdata(32'h0), .cpu_dmtype(3'b000),
    .cpu_rdata(to_rdata), .cpu_stall(to_stall), .cpu_err(to_err),
    .bus_req(to_req), .bus_we(to_we), .bus_be(to_be), .bus_addr(to_baddr),
    .bus_wdata(to_bwdata), .bus_rdata(to_bus_rdata), .bus_ready(to_ready)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model: plain arithmetic on access size and offset ----
  function automatic int sz_bytes(input logic [2:0] dt);
    case (dt)
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 4;
    endcase
  endfunction

  function automatic bit is_mis(input logic [2:0] dt, input logic [31:0] a);
    return (a % sz_bytes(dt)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] dt, input logic [31:0] a);
    int n;
    n = sz_bytes(dt);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] dt, input logic [31:0] wd);
    case (sz_bytes(dt))
      2:       return (wd % 65536) * 32'h00010001;
      1:       return (wd % 256) * 32'h01010101;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [31:0] a,
                                           input logic [2:0] dt);
    logic [31:0] v;
    v = word >> (8 * (a % 4));
    case (sz_bytes(dt))
      1: begin
        v = v % 256;
        if (dt == 3'd3 && v >= 128) v = v - 256;
      end
      2: begin
        v = v % 65536;
        if (dt == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: ;
    endcase
    return v;
  endfunction

  // One aligned access; the bench acts as the RAM and answers in the
  // wait_n-th BUSY cycle.
  task automatic do_access(input bit st, input bit ld, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [2:0] dt,
                           input int wait_n, input string tag,
                           output logic [31:0] o_rdata, output logic [3:0] o_be,
                           output logic [31:0] o_wdata, output int o_stalls);
    logic [3:0]  ebe;
    logic [31:0] ewd, word, eload;
    int          widx;
    ebe   = exp_be(dt, addr);
    ewd   = exp_wd(dt, wd);
    widx  = int'(addr[11:2]);
    word  = ram[widx];
    eload = exp_load(word, addr, dt);
    o_stalls = 0;
    o_be     = 4'h0;
    o_wdata  = 32'h0;

    @(negedge clk);
    cpu_mem_w = st; cpu_mem_r = ld; cpu_addr = addr; cpu_wdata = wd; cpu_dmtype = dt;
    #1;
    check({tag, ".stall_req"}, 32'(cpu_stall), 1);
    check({tag, ".req_early"}, 32'(bus_req), 0);
    if (cpu_stall) o_stalls++;

    for (int k = 1; k <= wait_n; k++) begin
      @(negedge clk);
      if (cpu_stall) o_stalls++;
      check({tag, ".busy_stall"}, 32'(cpu_stall), 1);
      check({tag, ".busy_req"}, 32'(bus_req), 1);
      check({tag, ".we"}, 32'(bus_we), 32'(st));
      check({tag, ".be"}, 32'(bus_be), 32'(ebe));
      check({tag, ".addr"}, 32'(bus_addr), addr >> 2);
      check({tag, ".wdata"}, bus_wdata, ewd);
      if (k == 1) begin
        o_be    = bus_be;
        o_wdata = bus_wdata;
      end
      if (k == wait_n) begin
        bus_ready = 1'b1;
        bus_rdata = word;
      end else begin
        bus_ready = 1'b0;
        bus_rdata = $urandom;
      end
    end

    @(negedge clk);
    if (st) begin
      for (int b = 0; b < 4; b++)
        if (ebe[b]) ram[widx][8*b +: 8] = ewd[8*b +: 8];
    end else begin
      m_rdata = eload;
    end
    check({tag, ".done_stall"}, 32'(cpu_stall), 0);
    check({tag, ".done_req"}, 32'(bus_req), 0);
    check({tag, ".done_err"}, 32'(cpu_err), 0);
    check({tag, ".rdata"}, cpu_rdata, m_rdata);
    o_rdata   = cpu_rdata;
    cpu_mem_w = 1'b0;
    cpu_mem_r = 1'b0;
    // stray ready while DONE/IDLE must be ignored
    bus_ready = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;

    @(negedge clk);
    bus_ready = 1'b0;
    check({tag, ".idle_req"}, 32'(bus_req), 0);
    check({tag, ".idle_stall"}, 32'(cpu_stall), 0);
    check({tag, ".idle_rdata"}, cpu_rdata, m_rdata);
  endtask

  task automatic do_misaligned(input bit st, input bit ld, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [2:0] dt,
                               input string tag);
    @(negedge clk);
    cpu_mem_w = st; cpu_mem_r = ld; cpu_addr = addr; cpu_wdata = wd; cpu_dmtype = dt;
    #1;
    check({tag, ".stall"}, 32'(cpu_stall), 0);
    @(negedge clk);
    m_rdata = 32'h0;
    check({tag, ".err"}, 32'(cpu_err), 1);
    check({tag, ".no_req"}, 32'(bus_req), 0);
    check({tag, ".rdata"}, cpu_rdata, m_rdata);
    cpu_mem_w = 1'b0;
    cpu_mem_r = 1'b0;
    @(negedge clk);
    check({tag, ".err_clr"}, 32'(cpu_err), 0);
    check({tag, ".no_req2"}, 32'(bus_req), 0);
  endtask

  initial begin
    logic [31:0] r, wd, a;
    logic [3:0]  be;
    int          stl, n, off, waddr;
    logic [2:0]  dt;
    bit          st, ld;

    rst = 1'b0;
    cpu_mem_w = 1'b0; cpu_mem_r = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_dmtype = '0;
    bus_rdata = '0; bus_ready = 1'b0;
    to_mem_r = 1'b0; to_addr = '0;
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[32'h200 >> 2] = 32'h80FF7F01;
    m_rdata = 32'h0;

    repeat (2) @(negedge clk);
    check("rst.bus_req", 32'(bus_req), 0);
    check("rst.bus_we", 32'(bus_we), 0);
    check("rst.bus_be", 32'(bus_be), 0);
    check("rst.bus_addr", 32'(bus_addr), 0);
    check("rst.bus_wdata", bus_wdata, 0);
    check("rst.cpu_rdata", cpu_rdata, 0);
    check("rst.cpu_err", 32'(cpu_err), 0);
    check("rst.cpu_stall", 32'(cpu_stall), 0);
    rst = 1'b1;
    @(negedge clk);

    // word store / load, zero-wait
    do_access(1, 0, 32'h100, 32'hDEADBEEF, 3'b000, 1, "sw", r, be, wd, stl);
    check("sw.be_const", 32'(be), 32'hF);
    check("sw.stalls", 32'(stl), 2);
    do_access(0, 1, 32'h100, 32'h0, 3'b000, 1, "lw", r, be, wd, stl);
    check("lw.rdata_const", r, 32'hDEADBEEF);
    check("lw.stalls", 32'(stl), 2);

    // extension
    do_access(0, 1, 32'h203, 32'h0, 3'b011, 1, "lb", r, be, wd, stl);
    check("lb.const", r, 32'hFFFFFF80);
    do_access(0, 1, 32'h203, 32'h0, 3'b100, 2, "lbu", r, be, wd, stl);
    check("lbu.const", r, 32'h00000080);
    do_access(0, 1, 32'h202, 32'h0, 3'b001, 1, "lh", r, be, wd, stl);
    check("lh.const", r, 32'hFFFF80FF);
    do_access(0, 1, 32'h200, 32'h0, 3'b010, 3, "lhu", r, be, wd, stl);
    check("lhu.const", r, 32'h00007F01);

    // sub-word stores
    do_access(1, 0, 32'h101, 32'h000000AB, 3'b011, 1, "sb", r, be, wd, stl);
    check("sb.be_const", 32'(be), 32'h2);
    check("sb.wd_const", wd, 32'hABABABAB);
    check("sb.rdata_held", r, 32'h00007F01);
    do_access(1, 0, 32'h102, 32'h00001234, 3'b001, 1, "sh", r, be, wd, stl);
    check("sh.be_const", 32'(be), 32'hC);
    check("sh.wd_const", wd, 32'h12341234);

    // wait states: ready in the 5th BUSY cycle
    do_access(0, 1, 32'h100, 32'h0, 3'b000, 5, "lw_wait", r, be, wd, stl);
    check("lw_wait.stalls", 32'(stl), 6);
    check("lw_wait.rdata_const", r, 32'h1234ABEF);

    // both requests set -> store; reserved dmtype -> word
    do_access(1, 1, 32'h108, 32'hCAFEF00D, 3'b000, 2, "sw_both", r, be, wd, stl);
    do_access(0, 1, 32'h200, 32'h0, 3'b110, 2, "lw_rsvd", r, be, wd, stl);
    check("lw_rsvd.const", r, 32'h80FF7F01);

    // misaligned
    do_misaligned(0, 1, 32'h102, 32'h0, 3'b000, "lw_mis");
    do_misaligned(1, 0, 32'h201, 32'h5555, 3'b001, "sh_mis");

    // timeout on the TIMEOUT=4 instance
    @(negedge clk);
    to_mem_r = 1'b1; to_addr = 32'h100;
    #1;
    check("to.stall_req", 32'(to_stall), 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("to.busy_req", 32'(to_req), 1);
      check("to.busy_stall", 32'(to_stall), 1);
      check("to.busy_err", 32'(to_err), 0);
    end
    @(negedge clk);
    check("to.done_req", 32'(to_req), 0);
    check("to.done_err", 32'(to_err), 1);
    check("to.done_stall", 32'(to_stall), 0);
    check("to.done_rdata", to_rdata, 0);
    to_mem_r = 1'b0;
    @(negedge clk);
    check("to.idle_err", 32'(to_err), 0);
    check("to.idle_req", 32'(to_req), 0);

    // reset two cycles into a wait
    @(negedge clk);
    cpu_mem_r = 1'b1; cpu_mem_w = 1'b0; cpu_addr = 32'h200; cpu_dmtype = 3'b000;
    bus_ready = 1'b0;
    @(negedge clk);
    check("mrst.busy1_req", 32'(bus_req), 1);
    @(negedge clk);
    check("mrst.busy2_req", 32'(bus_req), 1);
    rst = 1'b0;
    #1;
    m_rdata = 32'h0;
    check("mrst.bus_req", 32'(bus_req), 0);
    check("mrst.stall", 32'(cpu_stall), 0);
    check("mrst.rdata", cpu_rdata, m_rdata);
    check("mrst.be", 32'(bus_be), 0);
    check("mrst.addr", 32'(bus_addr), 0);
    check("mrst.wdata", bus_wdata, 0);
    check("mrst.err", 32'(cpu_err), 0);
    cpu_mem_r = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_access(0, 1, 32'h200, 32'h0, 3'b000, 3, "lw_after_rst", r, be, wd, stl);
    check("lw_after_rst.const", r, 32'h80FF7F01);
    check("lw_after_rst.stalls", 32'(stl), 4);

    // randomized accesses against the model
    for (int i = 0; i < 40; i++) begin
      dt    = 3'($urandom_range(0, 7));
      st    = 1'($urandom_range(0, 1));
      ld    = st ? 1'($urandom_range(0, 1)) : 1'b1;
      waddr = int'($urandom_range(0, 15));
      off   = int'($urandom_range(0, 3));
      n     = sz_bytes(dt);
      if ($urandom_range(0, 5) != 0) off = off - (off % n);
      a  = 32'h300 + 32'(waddr * 4 + off);
      wd = $urandom;
      if (is_mis(dt, a))
        do_misaligned(st, ld, a, wd, dt, "rnd_mis");
      else
        do_access(st, ld, a, wd, dt, int'($urandom_range(1, 4)), "rnd", r, be, wd, stl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
